wb_stage: RTL and testbench

// - Write-back stage of the 5-stage MIPS pipeline; consumes MEM/WB pipeline register outputs.
// - Selects write-back data, commits it to the 32x32 GPR file, and commits 64-bit multiply/divide results to HI/LO.
// - Serves the ID-stage GPR read ports and the HI/LO read port, with same-cycle write-through bypass.
// - Counts retired register-writing instructions.

---
 rtl/wb_stage_pkg.sv | 27 ++
 rtl/wb_stage_if.sv | 50 +++++
 rtl/wb_stage_gpr_file.sv | 44 ++++
 rtl/wb_stage.sv | 86 ++++++++
 tb/tb_wb_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths and write-back select encoding
// Purpose: default widths for the write-back stage and the encoding of the
//          write-back data source, plus the priority decode from the MEM/WB
//          control bits to that encoding.
// Contents: DW_DEF, AW_DEF, CNTW_DEF, wb_sel_e, wb_sel()
package wb_stage_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int CNTW_DEF = 32;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_SHF  = 2'd2,
    SEL_HILO = 2'd3
  } wb_sel_e;

  // mfhi/mflo outranks a shift, which outranks a load; ALU is the fallback.
  function automatic wb_sel_e wb_sel(input logic mf, input logic shift, input logic mem_to_reg);
    if (mf)              return SEL_HILO;
    else if (shift)      return SEL_SHF;
    else if (mem_to_reg) return SEL_MEM;
    else                 return SEL_ALU;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB control/data bundle and ID-side read bundle
// Purpose: groups every write-back stage signal except clk/rst.
// Modports:
//   master - pipeline side: drives MEM/WB fields and read addresses,
//            receives read data, forwarding info and the retire count
//   slave  - wb_stage side
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int CNTW = CNTW_DEF
) ();

  logic            RegWrite;
  logic            MemtoReg;
  logic            Shift;
  logic            Mf;
  logic            HiLoWrite;
  logic [DW-1:0]   ShifterData;
  logic [DW-1:0]   MemData;
  logic [DW-1:0]   ALUData;
  logic [DW-1:0]   HiLoData;
  logic [2*DW-1:0] DataForHiLo;
  logic [AW-1:0]   WN;
  logic [AW-1:0]   RA1;
  logic [AW-1:0]   RA2;
  logic            HiLoSel;
  logic [DW-1:0]   RD1;
  logic [DW-1:0]   RD2;
  logic [DW-1:0]   HiLoRd;
  logic [DW-1:0]   WBData;
  logic [AW-1:0]   WBWN;
  logic [CNTW-1:0] RetireCnt;

  modport master (
    output RegWrite, MemtoReg, Shift, Mf, HiLoWrite,
    output ShifterData, MemData, ALUData, HiLoData, DataForHiLo,
    output WN, RA1, RA2, HiLoSel,
    input  RD1, RD2, HiLoRd, WBData, WBWN, RetireCnt
  );

  modport slave (
    input  RegWrite, MemtoReg, Shift, Mf, HiLoWrite,
    input  ShifterData, MemData, ALUData, HiLoData, DataForHiLo,
    input  WN, RA1, RA2, HiLoSel,
    output RD1, RD2, HiLoRd, WBData, WBWN, RetireCnt
  );

endinterface

// File: rtl/wb_stage_gpr_file.sv
// rtl/wb_stage_gpr_file.sv - 2R1W general-purpose register file
// Purpose: 2**AW x DW registers, r0 hardwired to zero, combinational reads
//          with same-cycle write-through bypass.
// Ports:
//   clk, rst  - clock; synchronous active-high reset clears every register
//   we, wa, wd - write enable / address / data (writes to r0 are dropped)
//   ra1, ra2  - read addresses
//   rd1, rd2  - read data; forced to 0 while rst is high
module gpr_file #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // mem[0] is never written, but the read path does not rely on that.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst && (ra1 != '0)) rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
    if (!rst && (ra2 != '0)) rd2 = (we && (wa == ra2)) ? wd : mem[ra2];
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage: WB mux, GPR/HI/LO commit, retire count
// Purpose: selects write-back data, commits it to the GPR file, commits
//          64-bit mul/div results to HI/LO, serves GPR and HI/LO reads with
//          same-cycle bypass, and counts register-writing retirements.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous, active-high reset
//   bus - wb_stage_if.slave: MEM/WB inputs (RegWrite, MemtoReg, Shift, Mf,
//         HiLoWrite, ShifterData, MemData, ALUData, HiLoData, DataForHiLo,
//         WN), read requests (RA1, RA2, HiLoSel), and outputs (RD1, RD2,
//         HiLoRd, WBData, WBWN, RetireCnt)
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   bus
);

  logic [DW-1:0]   wb_data;
  logic [DW-1:0]   hi_q;
  logic [DW-1:0]   lo_q;
  logic [CNTW-1:0] cnt_q;

  always_comb begin
    wb_data = '0;
    unique case (wb_sel(bus.Mf, bus.Shift, bus.MemtoReg))
      SEL_HILO: wb_data = bus.HiLoData;
      SEL_SHF:  wb_data = bus.ShifterData;
      SEL_MEM:  wb_data = bus.MemData;
      SEL_ALU:  wb_data = bus.ALUData;
    endcase
  end

  gpr_file #(
    .DW (DW),
    .AW (AW)
  ) u_gpr_file (
    .clk (clk),
    .rst (rst),
    .we  (bus.RegWrite),
    .wa  (bus.WN),
    .wd  (wb_data),
    .ra1 (bus.RA1),
    .ra2 (bus.RA2),
    .rd1 (bus.RD1),
    .rd2 (bus.RD2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (bus.HiLoWrite) begin
        hi_q <= bus.DataForHiLo[2*DW-1:DW];
        lo_q <= bus.DataForHiLo[DW-1:0];
      end
      // Wraps silently at the top of the range.
      if (bus.RegWrite || bus.HiLoWrite) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  always_comb begin
    bus.HiLoRd = '0;
    bus.WBData = '0;
    bus.WBWN   = '0;
    if (!rst) begin
      if (bus.HiLoWrite)
        bus.HiLoRd = bus.HiLoSel ? bus.DataForHiLo[2*DW-1:DW] : bus.DataForHiLo[DW-1:0];
      else
        bus.HiLoRd = bus.HiLoSel ? hi_q : lo_q;
      bus.WBData = wb_data;
      // A zero tag tells the forwarding unit there is nothing to forward.
      if (bus.RegWrite && (bus.WN != '0)) bus.WBWN = bus.WN;
    end
  end

  assign bus.RetireCnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_stage_if #(.DW(DW), .AW(AW), .CNTW(CNTW)) bus ();

  wb_stage #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_gpr [32];
  logic [DW-1:0] m_hi, m_lo;
  int            m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.RegWrite = 0; bus.MemtoReg = 0; bus.Shift = 0; bus.Mf = 0; bus.HiLoWrite = 0;
    bus.ShifterData = '0; bus.MemData = '0; bus.ALUData = '0; bus.HiLoData = '0;
    bus.DataForHiLo = '0; bus.WN = '0; bus.RA1 = '0; bus.RA2 = '0; bus.HiLoSel = 0;
  endtask

  function automatic logic [DW-1:0] exp_wb();
    if (rst)               return '0;
    if (bus.Mf)            return bus.HiLoData;
    if (bus.Shift)         return bus.ShifterData;
    if (bus.MemtoReg)      return bus.MemData;
    return bus.ALUData;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (rst || ra == 0)               return '0;
    if (bus.RegWrite && bus.WN == ra) return exp_wb();
    return m_gpr[ra];
  endfunction

  function automatic logic [DW-1:0] exp_hilo();
    if (rst) return '0;
    if (bus.HiLoWrite) return bus.HiLoSel ? bus.DataForHiLo[63:32] : bus.DataForHiLo[31:0];
    return bus.HiLoSel ? m_hi : m_lo;
  endfunction

  // One cycle: check every output against the model mid-cycle, then advance
  // the model at the rising edge with the inputs the DUT saw.
  task automatic step();
    logic [DW-1:0] wbv;
    @(negedge clk);
    chk("RD1", bus.RD1, exp_rd(bus.RA1));
    chk("RD2", bus.RD2, exp_rd(bus.RA2));
    chk("HiLoRd", bus.HiLoRd, exp_hilo());
    chk("WBData", bus.WBData, exp_wb());
    chk("WBWN", bus.WBWN, (!rst && bus.RegWrite && bus.WN != 0) ? bus.WN : 0);
    chk("RetireCnt", bus.RetireCnt, m_cnt);
    wbv = exp_wb();
    @(posedge clk);
    if (rst) begin
      foreach (m_gpr[i]) m_gpr[i] = '0;
      m_hi = '0; m_lo = '0; m_cnt = 0;
    end else begin
      if (bus.RegWrite && bus.WN != 0) m_gpr[bus.WN] = wbv;
      if (bus.HiLoWrite) begin
        m_hi = bus.DataForHiLo[63:32];
        m_lo = bus.DataForHiLo[31:0];
      end
      if (bus.RegWrite || bus.HiLoWrite) m_cnt = (m_cnt + 1) % (2 ** CNTW);
    end
    #1;
  endtask

  initial begin
    foreach (m_gpr[i]) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0; m_cnt = 0;
    clear_in();

    // Reset with writes pending: outputs forced to 0, writes dropped.
    rst = 1;
    bus.RegWrite = 1; bus.WN = 5'd7; bus.ALUData = 32'h1234; bus.RA1 = 5'd7;
    bus.HiLoWrite = 1; bus.DataForHiLo = 64'hAAAA_BBBB_CCCC_DDDD; bus.HiLoSel = 1;
    step();
    step();
    clear_in();
    rst = 0;

    // Reset then read.
    bus.RA1 = 5'd7; bus.RA2 = 5'd0;
    #2;
    chk("rst_rd1", bus.RD1, 0);
    chk("rst_rd2", bus.RD2, 0);
    chk("rst_hilo", bus.HiLoRd, 0);
    chk("rst_cnt", bus.RetireCnt, 0);
    step();

    // Write r5 with same-cycle bypass, then from storage.
    bus.RegWrite = 1; bus.WN = 5'd5; bus.ALUData = 32'hDEADBEEF; bus.RA1 = 5'd5;
    #2;
    chk("byp_rd1", bus.RD1, 32'hDEADBEEF);
    step();
    bus.RegWrite = 0; bus.ALUData = '0;
    #2;
    chk("stor_rd1", bus.RD1, 32'hDEADBEEF);
    step();

    // Write to r0 is ignored and carries no forwarding tag.
    bus.RegWrite = 1; bus.WN = 5'd0; bus.ALUData = 32'h1; bus.RA1 = 5'd0;
    #2;
    chk("r0_rd1", bus.RD1, 0);
    chk("r0_wbwn", bus.WBWN, 0);
    step();
    clear_in();

    // Mux priority.
    bus.Mf = 1; bus.Shift = 1; bus.MemtoReg = 1;
    bus.HiLoData = 32'hA; bus.ShifterData = 32'hB; bus.MemData = 32'hC; bus.ALUData = 32'hD;
    #2;
    chk("mux_mf", bus.WBData, 32'hA);
    step();
    bus.Mf = 0;
    #2;
    chk("mux_shf", bus.WBData, 32'hB);
    step();
    bus.Shift = 0;
    #2;
    chk("mux_mem", bus.WBData, 32'hC);
    step();
    clear_in();

    // HI/LO write with bypass, then LO from storage.
    bus.HiLoWrite = 1; bus.DataForHiLo = 64'h11112222_33334444; bus.HiLoSel = 1;
    #2;
    chk("hilo_byp", bus.HiLoRd, 32'h11112222);
    step();
    bus.HiLoWrite = 0; bus.HiLoSel = 0;
    #2;
    chk("hilo_lo", bus.HiLoRd, 32'h33334444);
    step();

    // Reset mid-stream.
    rst = 1; clear_in(); step(); rst = 0;
    bus.RegWrite = 1; bus.WN = 5'd3; bus.ALUData = 32'd5;
    step(); step(); step();
    bus.RegWrite = 0; bus.RA1 = 5'd3;
    #2;
    chk("pre_r3", bus.RD1, 32'd5);
    chk("pre_cnt", bus.RetireCnt, 3);
    rst = 1; bus.RegWrite = 1; bus.WN = 5'd3; bus.ALUData = 32'd9;
    step();
    rst = 0; bus.RegWrite = 0;
    #2;
    chk("post_r3", bus.RD1, 0);
    chk("post_cnt", bus.RetireCnt, 0);
    bus.RegWrite = 1; bus.ALUData = 32'd7;
    step();
    bus.RegWrite = 0;
    #2;
    chk("first_wr", bus.RD1, 32'd7);

    // Counter wrap: drive to the top value, then one more retire.
    bus.HiLoWrite = 1;
    repeat (14) step();
    bus.HiLoWrite = 0;
    #2;
    chk("cnt_top", bus.RetireCnt, 15);
    bus.RegWrite = 1; bus.WN = 5'd9;
    step();
    bus.RegWrite = 0;
    #2;
    chk("cnt_wrap", bus.RetireCnt, 0);
    clear_in();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 39) == 0);
      bus.RegWrite    = $urandom_range(0, 1);
      bus.MemtoReg    = $urandom_range(0, 1);
      bus.Shift       = $urandom_range(0, 1);
      bus.Mf          = $urandom_range(0, 1);
      bus.HiLoWrite   = ($urandom_range(0, 3) == 0);
      bus.ShifterData = $urandom;
      bus.MemData     = $urandom;
      bus.ALUData     = $urandom;
      bus.HiLoData    = $urandom;
      bus.DataForHiLo = {$urandom, $urandom};
      bus.WN          = AW'($urandom_range(0, 7));
      bus.RA1         = ($urandom_range(0, 2) == 0) ? bus.WN : AW'($urandom_range(0, 7));
      bus.RA2         = AW'($urandom_range(0, 31));
      bus.HiLoSel     = $urandom_range(0, 1);
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
